// File: rtl/axis_src_pkg.sv
// Shared types and width helpers for the AXI4-Stream pattern source.
package axis_src_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int unsigned PAR_WDATA_BYTE_DFLT = 2;
    localparam int unsigned DATA_W_DFLT         = 8 * PAR_WDATA_BYTE_DFLT;

    function automatic int unsigned data_w(input int unsigned nbytes);
        return 8 * nbytes;
    endfunction

endpackage

// File: rtl/axis_pattern_src.sv
// AXI4-Stream transmitter: emits npkt packets of len arithmetic-progression words,
// separated by gap idle cycles, with fully registered outputs.
module axis_pattern_src
    import axis_src_pkg::*;
#(
    parameter int unsigned PAR_WDATA_BYTE = PAR_WDATA_BYTE_DFLT,
    parameter int unsigned PAR_LEN_W      = 8
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          start,
    input  logic [8*PAR_WDATA_BYTE-1:0]   cfg_seed,
    input  logic [8*PAR_WDATA_BYTE-1:0]   cfg_step,
    input  logic [PAR_LEN_W-1:0]          cfg_len,
    input  logic [7:0]                    cfg_npkt,
    input  logic [3:0]                    cfg_gap,
    output logic [8*PAR_WDATA_BYTE-1:0]   m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned DW = data_w(PAR_WDATA_BYTE);

    state_e                 state_q, state_d;
    logic [DW-1:0]          data_q, data_d;
    logic [DW-1:0]          step_q, step_d;
    logic [PAR_LEN_W-1:0]   len_q, len_d;
    logic [PAR_LEN_W-1:0]   wcnt_q, wcnt_d;
    logic [7:0]             npkt_q, npkt_d;
    logic [7:0]             pcnt_q, pcnt_d;
    logic [3:0]             gap_q, gap_d;
    logic [3:0]             gcnt_q, gcnt_d;

    logic [DW-1:0]          tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   xfer;
    logic                   last_word;
    logic                   last_pkt;
    logic                   final_xfer;

    assign xfer       = (state_q == SEND) && tvalid_q && m_axis_tready;
    assign last_word  = (wcnt_q == len_q - PAR_LEN_W'(1));
    assign last_pkt   = (pcnt_q == npkt_q - 8'd1);
    assign final_xfer = xfer && last_word && last_pkt;

    // State register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            data_q   <= '0;
            step_q   <= '0;
            len_q    <= '0;
            wcnt_q   <= '0;
            npkt_q   <= '0;
            pcnt_q   <= '0;
            gap_q    <= '0;
            gcnt_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            step_q   <= step_d;
            len_q    <= len_d;
            wcnt_q   <= wcnt_d;
            npkt_q   <= npkt_d;
            pcnt_q   <= pcnt_d;
            gap_q    <= gap_d;
            gcnt_q   <= gcnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        step_d  = step_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        npkt_d  = npkt_q;
        pcnt_d  = pcnt_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;
        case (state_q)
            IDLE: begin
                if (start && (cfg_len != '0) && (cfg_npkt != '0)) begin
                    state_d = SEND;
                    data_d  = cfg_seed;
                    step_d  = cfg_step;
                    len_d   = cfg_len;
                    npkt_d  = cfg_npkt;
                    gap_d   = cfg_gap;
                    wcnt_d  = '0;
                    pcnt_d  = '0;
                    gcnt_d  = '0;
                end
            end
            SEND: begin
                if (xfer) begin
                    // The progression runs on across packets; only the counters reset.
                    data_d = data_q + step_q;
                    if (last_word) begin
                        wcnt_d = '0;
                        if (last_pkt) begin
                            state_d = IDLE;
                        end else begin
                            pcnt_d  = pcnt_q + 8'd1;
                            gcnt_d  = '0;
                            state_d = (gap_q == 4'd0) ? SEND : GAP;
                        end
                    end else begin
                        wcnt_d = wcnt_q + PAR_LEN_W'(1);
                    end
                end
            end
            GAP: begin
                gcnt_d = gcnt_q + 4'd1;
                if (gcnt_q == gap_q - 4'd1) begin
                    state_d = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they appear as flops.
    always_comb begin
        tvalid_d = (state_d == SEND);
        tlast_d  = (state_d == SEND) && (wcnt_d == len_d - PAR_LEN_W'(1));
        tdata_d  = (state_d == IDLE) ? '0 : data_d;
        busy_d   = (state_d != IDLE);
        done_d   = final_xfer;
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_axis_pattern_src.sv
// Randomized self-checking bench for axis_pattern_src (16-bit and 8-bit instances).
module tb_axis_pattern_src;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        start;
    logic [15:0] cfg_seed, cfg_step;
    logic [7:0]  cfg_len, cfg_npkt;
    logic [3:0]  cfg_gap;
    logic [15:0] tdata;
    logic        tvalid, tlast, tready, busy, done;

    logic        start1, tready1;
    logic [7:0]  cfg1_seed, cfg1_step, cfg1_len, cfg1_npkt;
    logic [3:0]  cfg1_gap;
    logic [7:0]  tdata1;
    logic        tvalid1, tlast1, busy1, done1;

    int checks = 0;
    int failures = 0;

    always #5 aclk = ~aclk;

    axis_pattern_src #(.PAR_WDATA_BYTE(2), .PAR_LEN_W(8)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start),
        .cfg_seed(cfg_seed), .cfg_step(cfg_step), .cfg_len(cfg_len),
        .cfg_npkt(cfg_npkt), .cfg_gap(cfg_gap),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
        .m_axis_tready(tready), .busy(busy), .done(done)
    );

    axis_pattern_src #(.PAR_WDATA_BYTE(1), .PAR_LEN_W(8)) dut1 (
        .aclk(aclk), .aresetn(aresetn), .start(start1),
        .cfg_seed(cfg1_seed), .cfg_step(cfg1_step), .cfg_len(cfg1_len),
        .cfg_npkt(cfg1_npkt), .cfg_gap(cfg1_gap),
        .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tlast(tlast1),
        .m_axis_tready(tready1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one run and compares the collected stream with the arithmetic model.
    task automatic run(input logic [15:0] seed, input logic [15:0] step, input logic [7:0] len,
                       input logic [7:0] npkt, input logic [3:0] gap, input int rdy_pct,
                       input bit inj);
        logic [15:0] got_d[$];
        logic        got_l[$];
        logic [15:0] exp_d, pd;
        logic        pl;
        bit          pv, pr, seen_done;
        int          cyc, f, l, stab_err, nexp;
        @(negedge aclk);
        cfg_seed = seed; cfg_step = step; cfg_len = len; cfg_npkt = npkt; cfg_gap = gap;
        start = 1'b1; tready = 1'b0;
        cyc = 0; f = -1; l = -1; stab_err = 0; pv = 0; pr = 0; pd = '0; pl = 0; seen_done = 0;
        while (cyc < 4000) begin
            @(negedge aclk);
            start = 1'b0;
            if (inj && cyc == 3) begin
                start = 1'b1;
                cfg_seed = seed ^ 16'h5a5a; cfg_step = step + 16'd3;
                cfg_len = len + 8'd1; cfg_npkt = 8'd1; cfg_gap = 4'd0;
            end
            if (cyc == 0) begin
                chk("first_valid", {31'd0, tvalid}, 1);
                chk("first_data", {16'd0, tdata}, {16'd0, seed});
                chk("first_busy", {31'd0, busy}, 1);
            end
            if (pv && !pr && !(tvalid && tdata == pd && tlast == pl)) stab_err++;
            if (done) begin
                seen_done = 1;
                chk("done_valid", {31'd0, tvalid}, 0);
                chk("done_busy", {31'd0, busy}, 0);
                chk("done_lat", cyc, l + 1);
                break;
            end
            if (tvalid && f < 0) f = cyc;
            tready = ($urandom_range(99) < rdy_pct);
            if (tvalid && tready) begin
                got_d.push_back(tdata);
                got_l.push_back(tlast);
                l = cyc;
            end
            pv = tvalid; pr = tready; pd = tdata; pl = tlast;
            cyc++;
        end
        if (!seen_done) chk("timeout", 0, 1);
        @(negedge aclk);
        start = 1'b0;
        chk("done_once", {31'd0, done}, 0);
        chk("idle_valid", {31'd0, tvalid}, 0);
        chk("stable", stab_err, 0);
        nexp = int'(len) * int'(npkt);
        chk("nwords", got_d.size(), nexp);
        exp_d = seed;
        for (int k = 0; k < nexp && k < got_d.size(); k++) begin
            chk("word", {16'd0, got_d[k]}, {16'd0, exp_d});
            chk("last", {31'd0, got_l[k]}, {31'd0, (k % int'(len)) == int'(len) - 1});
            exp_d = exp_d + step;
        end
        if (rdy_pct >= 100)
            chk("cycles", l - f + 1, nexp + (int'(npkt) - 1) * int'(gap));
    endtask

    initial begin
        logic [7:0] exp1;
        int n;
        aresetn = 1'b0; start = 1'b0; tready = 1'b0;
        cfg_seed = '0; cfg_step = '0; cfg_len = '0; cfg_npkt = '0; cfg_gap = '0;
        start1 = 1'b0; tready1 = 1'b1;
        cfg1_seed = '0; cfg1_step = '0; cfg1_len = '0; cfg1_npkt = '0; cfg1_gap = '0;
        repeat (3) @(negedge aclk);
        chk("rst_valid", {31'd0, tvalid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_data", {16'd0, tdata}, 0);
        chk("rst_last", {31'd0, tlast}, 0);
        aresetn = 1'b1;

        run(16'h0010, 16'd1, 8'd4, 8'd2, 4'd0, 100, 0);
        run(16'h1234, 16'd7, 8'd2, 8'd3, 4'd3, 100, 0);
        run(16'($urandom), 16'($urandom), 8'd5, 8'd4, 4'($urandom_range(3)), 50, 0);
        run(16'hfff0, 16'h0009, 8'd1, 8'd5, 4'd2, 100, 0);
        run(16'h0100, 16'h0002, 8'd3, 8'd3, 4'd1, 100, 1);
        for (int r = 0; r < 4; r++)
            run(16'($urandom), 16'($urandom), 8'($urandom_range(1, 6)), 8'($urandom_range(1, 4)),
                4'($urandom_range(0, 5)), $urandom_range(30, 100), 0);

        // Degenerate configs never start a run.
        for (int d = 0; d < 2; d++) begin
            @(negedge aclk);
            cfg_len = (d == 0) ? 8'd0 : 8'd3;
            cfg_npkt = (d == 0) ? 8'd2 : 8'd0;
            start = 1'b1;
            n = 0;
            repeat (6) begin
                @(negedge aclk);
                start = 1'b0;
                if (tvalid || busy || done) n++;
            end
            chk("degenerate", n, 0);
        end

        // 8-bit wrap.
        @(negedge aclk);
        cfg1_seed = 8'hfe; cfg1_step = 8'd1; cfg1_len = 8'd4; cfg1_npkt = 8'd1; cfg1_gap = 4'd0;
        start1 = 1'b1;
        exp1 = 8'hfe;
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            start1 = 1'b0;
            chk("w1_valid", {31'd0, tvalid1}, 1);
            chk("w1_data", {24'd0, tdata1}, {24'd0, exp1});
            chk("w1_last", {31'd0, tlast1}, {31'd0, k == 3});
            exp1 = exp1 + 8'd1;
        end
        @(negedge aclk);
        chk("w1_done", {31'd0, done1}, 1);
        chk("w1_busy", {31'd0, busy1}, 0);

        // Reset during the third word of an 8-word run.
        @(negedge aclk);
        cfg_seed = 16'h0400; cfg_step = 16'd1; cfg_len = 8'd4; cfg_npkt = 8'd2; cfg_gap = 4'd0;
        start = 1'b1; tready = 1'b1;
        n = 0;
        while (n < 50 && !(tvalid && tdata == 16'h0402)) begin
            @(negedge aclk);
            start = 1'b0;
            n++;
        end
        chk("rst_reach", {31'd0, n < 50}, 1);
        aresetn = 1'b0;
        @(negedge aclk);
        chk("mid_rst_out", {12'd0, tdata, tvalid, tlast, busy, done}, 0);
        aresetn = 1'b1;
        n = 0;
        repeat (5) begin
            @(negedge aclk);
            if (done || tvalid) n++;
        end
        chk("post_rst_quiet", n, 0);
        run(16'h0400, 16'd1, 8'd4, 8'd2, 4'd0, 100, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/axis_pattern_src.md
# axis_pattern_src

AXI4-Stream transmitter for the sum datapath. On a start pulse it latches a configuration and emits a programmable train of packets. Each packet is a run of arithmetic-progression words terminated by `tlast`, with an optional idle gap between packets. It drives the slave side of the stream register slice and sum blocks, honours backpressure, and serves as the stimulus end of the stream in system tests and on-chip self-test.

## Interface
- PAR_WDATA_BYTE, 2, data bus width in bytes (1..2)
- PAR_LEN_W, 8, width of packet-length configuration
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- start  in  1  single-cycle request; sampled only in IDLE
- cfg_seed  in  8*PAR_WDATA_BYTE  first data word of the run
- cfg_step  in  8*PAR_WDATA_BYTE  increment between consecutive words
- cfg_len  in  PAR_LEN_W  words per packet
- cfg_npkt  in  8  packets per run
- cfg_gap  in  4  idle cycles between packets
- m_axis_tdata  out  8*PAR_WDATA_BYTE  stream data
- m_axis_tvalid  out  1  stream valid
- m_axis_tlast  out  1  last word of packet
- m_axis_tready  in  1  stream ready
- busy  out  1  run in progress
- done  out  1  one-cycle pulse after the final transfer of a run

## Operation
- States: IDLE, SEND, GAP.
- IDLE: all outputs low. If `start`=1 and `cfg_len`≠0 and `cfg_npkt`≠0, latch all cfg_* values, load data=seed, word and packet counters=0, and go to SEND. Otherwise stay in IDLE, and do not pulse `done`.
- SEND: `tvalid`=1. `tdata`=current word. `tlast`=1 when the word counter = len−1.
- Transfer condition: `tvalid`&&`tready`. On each transfer, data += step (modulo 2^(8*PAR_WDATA_BYTE), wraps silently) and the word counter advances.
- Transfer with `tlast`=1:
  - Packet counter = npkt−1: go to IDLE and assert `done` for one cycle.
  - Otherwise, if gap=0: stay in SEND with no bubble.
  - Otherwise: go to GAP.
- The data sequence continues across packet boundaries; it does not restart at seed per packet.
- GAP: `tvalid`=0 for exactly `gap` cycles, then SEND.
- AXIS rule: once `tvalid`=1, `tdata`/`tlast` stay stable until the transfer. `tvalid` never drops without a transfer.
- `start` outside IDLE is ignored. cfg_* changes after the latch have no effect on the current run.
- `busy`=1 in SEND and GAP.

## Timing
- All outputs are registered. Reset values: `tdata`=0, `tvalid`=0, `tlast`=0, `busy`=0, `done`=0. State=IDLE, counters=0.
- `start` is sampled at edge N. `tvalid`/`busy` go high after edge N, with `tdata`=seed.
- With `tready` held at 1: one word per cycle. A run of len×npkt words lasts len×npkt + (npkt−1)×gap cycles from the first `tvalid`.
- The final transfer occurs at edge M. After M: `tvalid`=0, `busy`=0, `done`=1 for one cycle. The earliest new `start` is accepted at edge M+1.
- `tready` low: the current word is held indefinitely. Gap cycles are counted only in GAP, never while stalled.
- len=1: every word carries `tlast`=1.
- Reset asserted mid-run: all outputs go to reset values after the next edge. No `done` is generated. The partial packet is abandoned.

## Structure
- Shared package `axis_src_pkg`: state enum typedef (IDLE/SEND/GAP), and a localparam for the data width derived from PAR_WDATA_BYTE.
- Single module; no sub-module required.
- The output is registered, so it connects directly to the existing stream register slice or sum block.

## Test plan
- Basic run (W=2): seed=0x0010, step=1, len=4, npkt=2, gap=0, `tready`=1 -> 8 consecutive words 0x0010..0x0017. `tlast` on 0x0013 and 0x0017. `done` the cycle after 0x0017.
- Gap: len=2, npkt=3, gap=3 -> exactly 3 `tvalid`=0 cycles between packets. Total 12 cycles from the first `tvalid` to the last transfer.
- Backpressure: random `tready` (≈50%), len=5, npkt=4 -> `tdata`/`tlast` stable while stalled. Received sequence identical to the stall-free case. Exactly one `done`.
- Wrap and degenerate config: W=1, seed=0xFE, step=1, len=4, npkt=1 -> 0xFE, 0xFF, 0x00, 0x01. Then len=0 or npkt=0 with `start` -> no `tvalid`, no `busy`, no `done`.
- Start while busy: second `start` mid-run with different cfg -> ignored. The output matches the first cfg.
- Reset mid-run: `aresetn`=0 during word 3 of 8 -> all outputs 0 the next cycle and no `done`. A new `start` after reset release runs cleanly from seed.
